// File: rtl/uart_hex_reporter_pkg.sv
// Shared ASCII constants and FSM state type for the hex reporter.
package uart_hex_reporter_pkg;

    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to ASCII hex digit.
module nibble_to_ascii
    import uart_hex_reporter_pkg::*;
#(
    parameter int UPPERCASE = 1
) (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    logic [7:0] w_alpha_base;

    assign w_alpha_base = (UPPERCASE != 0) ? ASCII_UPPER_A : ASCII_LOWER_A;

    always_comb begin
        if (i_nibble <= 4'd9)
            o_ascii = ASCII_0 + {4'd0, i_nibble};
        else
            o_ascii = w_alpha_base + {4'd0, i_nibble} - 8'd10;
    end

endmodule

// File: rtl/uart_hex_reporter.sv
// Turns an accepted byte into two ASCII hex digits (plus optional CR LF)
// and feeds them one at a time into the UART transmitter handshake.
module uart_hex_reporter
    import uart_hex_reporter_pkg::*;
#(
    parameter int APPEND_CRLF = 1,
    parameter int UPPERCASE   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_dv,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic       o_busy
);

    localparam logic [1:0] LAST_IDX = (APPEND_CRLF != 0) ? 2'd3 : 2'd1;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_idx, w_idx_nxt;
    logic [7:0] r_byte, w_byte_nxt;
    logic [7:0] r_tx_byte;
    logic       r_ready, r_busy, r_tx_dv;
    logic       w_load;
    logic [3:0] w_nibble;
    logic [7:0] w_ascii, w_char;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // A done pulse outside WAIT is stale and deliberately ignored; in WAIT it
    // outranks i_tx_active.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_byte_nxt  = r_byte;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_byte_valid && r_ready) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = 2'd0;
                    w_byte_nxt  = i_byte;
                    w_load      = 1'b1;
                end
            end
            SEND: begin
                if (i_tx_active) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = SEND;
                        w_idx_nxt   = r_idx + 2'd1;
                        w_load      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The character for the upcoming index is prepared from next-state values
    // so it is already registered on the first SEND cycle.
    assign w_nibble = (w_idx_nxt == 2'd0) ? w_byte_nxt[7:4] : w_byte_nxt[3:0];

    nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_hex (
        .i_nibble (w_nibble),
        .o_ascii  (w_ascii)
    );

    always_comb begin
        case (w_idx_nxt)
            2'd0, 2'd1: w_char = w_ascii;
            2'd2:       w_char = ASCII_CR;
            default:    w_char = ASCII_LF;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx     <= 2'd0;
            r_byte    <= 8'h00;
            r_tx_byte <= 8'h00;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_dv   <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_byte  <= w_byte_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt != IDLE);
            r_tx_dv <= (w_state_nxt == SEND);
            if (w_load) r_tx_byte <= w_char;
        end
    end

    assign o_byte_ready = r_ready;
    assign o_busy       = r_busy;
    assign o_tx_dv      = r_tx_dv;
    assign o_tx_byte    = r_tx_byte;

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Three reporter configurations (default, lowercase, no CR LF), each driving
// a small transmitter model; sent characters are checked against a scoreboard.
module tb_uart_hex_reporter;

    localparam bit [2:0] CRLF_P = 3'b011;
    localparam bit [2:0] UC_P   = 3'b101;
    localparam int       FRAME  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0][7:0] byte_in = '0;
    logic [2:0]      vld = '0;
    logic [2:0]      rdy, busy, dv;
    logic [2:0][7:0] txb;
    logic [2:0]      mdl_act = '0;
    logic [2:0]      mdl_done = '0;
    logic [2:0]      inj_done = '0;

    bit   hold [3] = '{0, 0, 0};
    int   cnt [3] = '{0, 0, 0};
    int   n_done [3] = '{0, 0, 0};
    int   n_cap [3] = '{0, 0, 0};
    logic [7:0] exp_q [3][$];
    logic [7:0] obs_q [3][$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_hex_reporter #(
            .APPEND_CRLF (int'(CRLF_P[g])),
            .UPPERCASE   (int'(UC_P[g]))
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_byte       (byte_in[g]),
            .i_byte_valid (vld[g]),
            .o_byte_ready (rdy[g]),
            .o_tx_byte    (txb[g]),
            .o_tx_dv      (dv[g]),
            .i_tx_active  (mdl_act[g]),
            .i_tx_done    (mdl_done[g] | inj_done[g]),
            .o_busy       (busy[g])
        );
    end

    // Transmitter model: latch character on dv, stay active FRAME cycles,
    // then pulse done. Runs on the falling edge, unaffected by DUT reset.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            mdl_done[g] = 1'b0;
            if (!mdl_act[g]) begin
                if (dv[g] && !hold[g]) begin
                    mdl_act[g] = 1'b1;
                    cnt[g]     = FRAME;
                    obs_q[g].push_back(txb[g]);
                end
            end else if (cnt[g] == 0) begin
                mdl_act[g]  = 1'b0;
                mdl_done[g] = 1'b1;
                n_done[g]++;
            end else begin
                cnt[g]--;
            end
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++)
            if (rst_n && vld[g] && rdy[g]) n_cap[g]++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input int g, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input int n);
        exp_q[g].push_back(a);
        exp_q[g].push_back(b);
        if (n > 2) begin
            exp_q[g].push_back(c);
            exp_q[g].push_back(d);
        end
    endtask

    task automatic compare_one(input int g, input string tag);
        logic [7:0] o, e;
        o = (obs_q[g].size() > 0) ? obs_q[g].pop_front() : 8'hxx;
        e = (exp_q[g].size() > 0) ? exp_q[g].pop_front() : 8'hxx;
        check(tag, {24'd0, o}, {24'd0, e});
    endtask

    task automatic send(input int g, input logic [7:0] b, input logic [7:0] first,
                        input bit keep, input logic [7:0] nxt, input string tag);
        int t = 0;
        byte_in[g] = b;
        vld[g]     = 1'b1;
        while (!rdy[g] && t < 50) begin
            step();
            t++;
        end
        check({tag, "_accept"}, {31'd0, rdy[g]}, 32'd1);
        step();
        if (keep) byte_in[g] = nxt;
        else      vld[g] = 1'b0;
        check({tag, "_rdy_low"}, {31'd0, rdy[g]}, 32'd0);
        check({tag, "_dv_high"}, {31'd0, dv[g]}, 32'd1);
        check({tag, "_first"}, {24'd0, txb[g]}, {24'd0, first});
    endtask

    task automatic expect_chars(input int g, input int n, input string tag);
        int base, t;
        for (int k = 0; k < n; k++) begin
            base = n_done[g];
            t    = 0;
            while (n_done[g] == base && t < 300) begin
                step();
                t++;
            end
            check({tag, "_done_seen"}, {31'd0, n_done[g] != base}, 32'd1);
            check({tag, "_rdy_low_at_done"}, {31'd0, rdy[g]}, 32'd0);
            compare_one(g, {tag, "_char"});
        end
        step();
        check({tag, "_rdy_return"}, {31'd0, rdy[g]}, 32'd1);
        check({tag, "_busy_clear"}, {31'd0, busy[g]}, 32'd0);
    endtask

    initial begin
        int t, base;

        step();
        step();
        check("reset_rdy", {29'd0, rdy}, 32'd0);
        check("reset_busy", {29'd0, busy}, 32'd0);
        check("reset_dv", {29'd0, dv}, 32'd0);
        check("reset_txb", {8'd0, txb}, 32'd0);
        rst_n = 1'b1;
        check("rel_rdy_still_low", {29'd0, rdy}, 32'd0);
        step();
        check("rel_rdy_high", {29'd0, rdy}, 32'd7);
        check("rel_busy_low", {29'd0, busy}, 32'd0);

        // Defaults, 0x3A
        push4(0, 8'h33, 8'h41, 8'h0D, 8'h0A, 4);
        send(0, 8'h3A, 8'h33, 1'b0, 8'h00, "t1");
        check("t1_busy", {31'd0, busy[0]}, 32'd1);
        expect_chars(0, 4, "t1");

        // Lowercase, 0xFF
        push4(1, 8'h66, 8'h66, 8'h0D, 8'h0A, 4);
        send(1, 8'hFF, 8'h66, 1'b0, 8'h00, "t2");
        expect_chars(1, 4, "t2");

        // Digits only, 0x09
        push4(2, 8'h30, 8'h39, 8'h00, 8'h00, 2);
        send(2, 8'h09, 8'h30, 1'b0, 8'h00, "t3");
        expect_chars(2, 2, "t3");
        step();
        step();
        step();
        check("t3_no_extra_chars", obs_q[2].size(), 32'd0);
        check("t3_dv_idle", {31'd0, dv[2]}, 32'd0);

        // Back-to-back with valid held: 0x12 then 0xBE
        base = n_cap[0];
        push4(0, 8'h31, 8'h32, 8'h0D, 8'h0A, 4);
        push4(0, 8'h42, 8'h45, 8'h0D, 8'h0A, 4);
        send(0, 8'h12, 8'h31, 1'b1, 8'hBE, "t4a");
        expect_chars(0, 4, "t4a");
        step();
        vld[0] = 1'b0;
        check("t4b_dv", {31'd0, dv[0]}, 32'd1);
        check("t4b_first", {24'd0, txb[0]}, 32'h42);
        expect_chars(0, 4, "t4b");
        step();
        step();
        check("t4_captures", n_cap[0] - base, 32'd2);

        // Spurious done while in SEND
        hold[0] = 1'b1;
        push4(0, 8'h35, 8'h41, 8'h0D, 8'h0A, 4);
        send(0, 8'h5A, 8'h35, 1'b0, 8'h00, "t5");
        inj_done[0] = 1'b1;
        step();
        inj_done[0] = 1'b0;
        check("t5_dv_held", {31'd0, dv[0]}, 32'd1);
        check("t5_idx_held", {24'd0, txb[0]}, 32'h35);
        step();
        check("t5_dv_still", {31'd0, dv[0]}, 32'd1);
        hold[0] = 1'b0;
        expect_chars(0, 4, "t5");

        // Reset during the second character's WAIT
        push4(0, 8'h35, 8'h35, 8'h0D, 8'h0A, 4);
        send(0, 8'h55, 8'h35, 1'b0, 8'h00, "t6");
        base = n_done[0];
        t    = 0;
        while (n_done[0] == base && t < 300) begin
            step();
            t++;
        end
        check("t6_first_done", {31'd0, n_done[0] != base}, 32'd1);
        t = 0;
        while (!(mdl_act[0] && !dv[0]) && t < 50) begin
            step();
            t++;
        end
        check("t6_in_wait", {31'd0, mdl_act[0] && !dv[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rdy", {31'd0, rdy[0]}, 32'd0);
        check("t6_rst_busy", {31'd0, busy[0]}, 32'd0);
        check("t6_rst_dv", {31'd0, dv[0]}, 32'd0);
        check("t6_rst_txb", {24'd0, txb[0]}, 32'd0);
        compare_one(0, "t6_char0");
        compare_one(0, "t6_char1");
        exp_q[0].delete();
        obs_q[0].delete();
        step();
        rst_n = 1'b1;
        check("t6_rel_rdy_low", {31'd0, rdy[0]}, 32'd0);
        step();
        check("t6_rel_rdy_high", {31'd0, rdy[0]}, 32'd1);
        t = 0;
        while ((mdl_act[0] || mdl_done[0]) && t < 50) begin
            step();
            t++;
        end
        check("t6_tx_drained", {30'd0, mdl_act[0], mdl_done[0]}, 32'd0);
        check("t6_no_stray_char", obs_q[0].size(), 32'd0);
        push4(0, 8'h37, 8'h43, 8'h0D, 8'h0A, 4);
        send(0, 8'h7C, 8'h37, 1'b0, 8'h00, "t6n");
        expect_chars(0, 4, "t6n");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
